// File: rtl/rcpu_io_pkg.sv
// rtl/rcpu_io_pkg.sv - shared constants and FSM state types for the RCPU IO UART
// Contents:
//   REG_DATA / REG_STATUS : register offsets from the peripheral base address
//   ST_*                  : bit positions inside the STATUS word
//   tx_state_e/rx_state_e : serialiser / deserialiser FSM states
package rcpu_io_pkg;

  localparam logic [15:0] REG_DATA   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_TX_IDLE    = 3;
  localparam int ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/rcpu_sync_fifo.sv
// rtl/rcpu_sync_fifo.sv - single-clock FIFO with extra-MSB pointers
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   push_i, wdata_i     : write request and data (ignored when full unless popping)
//   pop_i, rdata_o      : read request and head-of-queue data (show-ahead)
//   full_o, empty_o     : occupancy flags
module rcpu_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rcpu_io_uart.sv
// rtl/rcpu_io_uart.sv - memory-mapped 8N1 UART on the RCPU io_* bus
// Ports:
//   clk, resetq                     : clock, asynchronous active-low reset
//   io_read_enable, io_write_enable : one-cycle CPU access strobes
//   io_address, io_write_data       : 16-bit address (full decode), write data [7:0]
//   io_read_data                    : registered read data, one cycle after the strobe
//   uart_rx, uart_tx                : serial lines, idle high
module rcpu_io_uart
  import rcpu_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_ONE  = 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + REG_STATUS;

  // Bus decode
  logic sel_data, sel_status, data_rd, status_rd;
  logic unused_wdata_hi;
  assign sel_data        = (io_address == DATA_ADDR);
  assign sel_status      = (io_address == STATUS_ADDR);
  assign data_rd         = io_read_enable && sel_data;
  assign status_rd       = io_read_enable && sel_status;
  assign unused_wdata_hi = ^io_write_data[15:8];

  // FIFOs
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_rdata, rx_rdata;

  assign tx_push = io_write_enable && sel_data;
  assign rx_pop  = data_rd && !rx_empty;

  rcpu_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i(clk), .rst_ni(resetq), .push_i(tx_push), .wdata_i(io_write_data[7:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty)
  );

  // TX serialiser
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_out_q, tx_out_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q + BAUD_ONE;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_baud_d = '0;
        tx_out_d  = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_state_d = TX_START;
          tx_out_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_out_d   = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          // Chain straight into the next start bit so frames have no gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_rdata;
            tx_state_d = TX_START;
            tx_out_d   = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_out_d   = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign uart_tx = tx_out_q;

  // RX deserialiser; rx_prev_q gives falling-edge detection on the synchronised line
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          ovr_set, fe_set;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q + BAUD_ONE;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start check; later samples fall a whole bit apart from here.
        if (rx_baud_q == BAUD_HALF) begin
          rx_baud_d = '0;
          rx_bit_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_push = 1'b1;
            // A concurrent CPU pop makes room, so that is not an overrun.
            if (rx_full && !rx_pop) ovr_set = 1'b1;
          end else begin
            fe_set = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  rcpu_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i(clk), .rst_ni(resetq), .push_i(rx_push), .wdata_i(rx_shift_q),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty)
  );

  // Sticky flags: a set in the same cycle as the clearing read wins.
  logic overrun_q, overrun_d, frame_err_q, frame_err_d;
  assign overrun_d   = ovr_set | (overrun_q & ~status_rd);
  assign frame_err_d = fe_set | (frame_err_q & ~status_rd);

  logic [15:0] status_word, rd_data_q, rd_data_d;

  always_comb begin
    status_word                = '0;
    status_word[ST_RX_VALID]   = !rx_empty;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_RX_OVERRUN] = overrun_q;
    status_word[ST_TX_IDLE]    = (tx_state_q == TX_IDLE) && tx_empty;
    status_word[ST_FRAME_ERR]  = frame_err_q;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (io_read_enable) begin
      rd_data_d = '0;
      if (sel_data && !rx_empty) rd_data_d = {8'h00, rx_rdata};
      else if (sel_status)       rd_data_d = status_word;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign io_read_data = rd_data_q;

endmodule

// File: tb/tb_rcpu_io_uart.sv
// tb/tb_rcpu_io_uart.sv - scoreboard bench for rcpu_io_uart
module tb_rcpu_io_uart;

  localparam int CPB = 8;
  localparam int DEP = 4;
  localparam logic [15:0] A_DATA = 16'h0000;
  localparam logic [15:0] A_STAT = 16'h0001;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = 16'h0000;
  logic [15:0] io_write_data = 16'h0000;
  logic [15:0] io_read_data;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0]  tx_exp_q[$];
  logic [7:0]  got_q[$];
  int          got_start_q[$];
  bit          got_ok_q[$];
  logic [15:0] rd_exp_q[$];

  rcpu_io_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .resetq(resetq),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Serial monitor: decode frames on uart_tx at mid-bit.
  initial begin
    logic [7:0] b;
    logic       st, sp;
    int         t0;
    forever begin
      @(negedge clk);
      if (resetq === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        st = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_tx;
        got_q.push_back(b);
        got_start_q.push_back(t0);
        got_ok_q.push_back(st == 1'b0 && sp == 1'b1);
      end
    end
  end

  // Tasks start and end on a falling clock edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    io_address = a;
    io_write_data = d;
    io_write_enable = 1'b1;
    @(negedge clk);
    io_write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    io_address = a;
    io_read_enable = 1'b1;
    @(negedge clk);
    io_read_enable = 1'b0;
    v = io_read_data;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    total++;
    if (io_read_data !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", io_read_data); end
    resetq = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL reset_status: got %h want 0008", v); end
  endtask

  task automatic test_tx_single();
    logic [9:0]  frame;
    logic [15:0] v;
    frame = {1'b1, 8'h55, 1'b0};
    tx_exp_q.push_back(8'h55);
    bus_write(A_DATA, 16'h0055);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      total++;
      if (uart_tx !== frame[k / CPB]) begin
        bad++;
        $display("FAIL tx_wave[%0d]: got %b want %b", k, uart_tx, frame[k / CPB]);
      end
    end
    repeat (4) @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL tx_single_status: got %h want 0008", v); end
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL tx_single_frames: got %0d want 1", got_q.size());
    end else begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = tx_exp_q.pop_front();
      void'(got_start_q.pop_front());
      total++;
      if (g !== e || !got_ok_q.pop_front()) begin bad++; $display("FAIL tx_single_byte: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    int          budget;
    int          starts[5];
    for (int i = 1; i <= 5; i++) begin
      tx_exp_q.push_back(8'(i));
      bus_write(A_DATA, 16'(i));
    end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL b2b_full_status: got %h want 0002", v); end
    bus_write(A_DATA, 16'h0006);   // FIFO full: must be dropped
    budget = 0;
    while (got_q.size() < 5 && budget < 700) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (got_q.size() < 5) begin
      bad++; $display("FAIL b2b_timeout: got %0d frames want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0] g, e;
        bit ok;
        g = got_q.pop_front(); e = tx_exp_q.pop_front();
        ok = got_ok_q.pop_front();
        starts[i] = got_start_q.pop_front();
        total++;
        if (g !== e || !ok) begin bad++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, g, e); end
        if (i > 0) begin
          total++;
          if (starts[i] - starts[i-1] != 10 * CPB) begin
            bad++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, starts[i] - starts[i-1], 10 * CPB);
          end
        end
      end
    end
    repeat (120) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL b2b_drop: got %0d extra frames want 0", got_q.size()); end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL b2b_idle_status: got %h want 0008", v); end
  endtask

  task automatic test_rx_single();
    logic [15:0] v, e;
    rd_exp_q.push_back(16'h00A3);
    drive_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0009) begin bad++; $display("FAIL rx_status: got %h want 0009", v); end
    bus_read(A_DATA, v);
    e = rd_exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL rx_data: got %h want %h", v, e); end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL rx_status_after: got %h want 0008", v); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0]  bytes[5];
    logic [15:0] v, e;
    int          n;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      if (rd_exp_q.size() < DEP) rd_exp_q.push_back({8'h00, bytes[i]});
      drive_frame(bytes[i], 1'b1);
    end
    repeat (4) @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h000D) begin bad++; $display("FAIL ovr_status: got %h want 000d", v); end
    n = 0;
    while (rd_exp_q.size() > 0) begin
      bus_read(A_DATA, v);
      e = rd_exp_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL ovr_data[%0d]: got %h want %h", n, v, e); end
      n++;
    end
    bus_read(A_DATA, v);
    total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL ovr_empty_read: got %h want 0000", v); end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL ovr_status_after: got %h want 0008", v); end
  endtask

  task automatic test_frame_error();
    logic [15:0] v;
    drive_frame(8'h5A, 1'b0);
    repeat (10) @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0018) begin bad++; $display("FAIL fe_status: got %h want 0018", v); end
    bus_read(A_DATA, v);
    total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL fe_no_push: got %h want 0000", v); end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL fe_status_after: got %h want 0008", v); end
  endtask

  task automatic test_unmapped();
    logic [15:0] v;
    bus_write(16'h0002, 16'h00AA);
    bus_write(A_STAT, 16'h00BB);
    repeat (3) @(negedge clk);
    bus_read(16'h0002, v);
    total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL unmapped_read: got %h want 0000", v); end
    bus_read(16'h0101, v);
    total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL alias_read: got %h want 0000", v); end
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL unmapped_status: got %h want 0008", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    drive_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    bus_write(A_DATA, 16'h00C3);
    bus_read(A_DATA, v);
    total++;
    if (v !== 16'h007E) begin bad++; $display("FAIL rst_pre_data: got %h want 007e", v); end
    total++;
    if (uart_tx !== 1'b0) begin bad++; $display("FAIL rst_pre_tx: got %b want 0", uart_tx); end
    #2 resetq = 1'b0;
    #1;
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_async_tx: got %b want 1", uart_tx); end
    total++;
    if (io_read_data !== 16'h0000) begin bad++; $display("FAIL rst_async_rdata: got %h want 0000", io_read_data); end
    @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_STAT, v);
    total++;
    if (v !== 16'h0008) begin bad++; $display("FAIL rst_status_after: got %h want 0008", v); end
    repeat (100) @(negedge clk);
    got_q.delete();
    got_start_q.delete();
    got_ok_q.delete();
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_frame_error();
    test_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
